// File: rtl/ro_freq_counter.sv
// ---------------------------------------------------------------------------
// ro_freq_counter
//
// Purpose:
//   Measures the frequency of a ring-oscillator output. It counts the rising
//   edges of ro_in over a window of gate_cycles wb_clk_i cycles.
//   ro_in is asynchronous to wb_clk_i. It is brought into the clock domain
//   through a 2-flop synchronizer. A third flop follows for edge detection.
//   Inputs faster than half the clock rate are not counted reliably. The
//   oscillator path is expected to prescale them first.
//
//   Measurement sequence:
//     IDLE/DONE --start--> ARM   (1 cycle: clear results, latch window)
//     ARM       ---------> COUNT (gate_cycles cycles) or DONE if window is 0
//     COUNT     ---------> DONE  (results held until start or abort)
//     any state --abort--> IDLE  (results cleared; abort beats start)
//
// Parameters:
//   CNT_W   - width of the edge-count result
//   GATE_W  - width of the gate-length input (in clock cycles)
//
// Ports:
//   wb_clk_i     in   clock; every state change happens on its rising edge
//   wb_rst_ni    in   asynchronous active-low reset
//   ro_in        in   selected ring-oscillator output (asynchronous)
//   start        in   one-cycle request to begin a measurement
//   abort        in   synchronous cancel, returns to IDLE
//   gate_cycles  in   measurement window length in clock cycles
//   count_o      out  rising edges counted in the last window (saturating)
//   busy         out  high while in ARM or COUNT
//   done         out  high while in DONE
//   overflow     out  sticky flag: an edge arrived while count_o was all-ones
//   irq          out  one-cycle pulse on every entry into DONE
//
// Build option:
//   RO_FREQ_IRQ_EN - when defined, irq pulses on every entry into DONE.
//                    When undefined, irq is tied to 0 and no irq logic is
//                    generated.
// ---------------------------------------------------------------------------
module ro_freq_counter #(
   parameter int CNT_W  = 24,
   parameter int GATE_W = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              ro_in,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_cycles,
   output logic [CNT_W-1:0]  count_o,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              irq
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;

   logic               sync1;
   logic               sync2;
   logic               sync3;
   logic               ro_rise;

   logic [GATE_W-1:0]  gate_rem;
   logic [GATE_W-1:0]  gate_rem_next;
   logic [CNT_W-1:0]   count_next;
   logic               overflow_next;
   logic               count_full;

   // The synchronizer chain resets to 0. A high ro_in at reset release
   // can only produce an edge while the FSM sits in IDLE. Edges are counted
   // only in COUNT, so that stale edge is never counted.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= ro_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign ro_rise    = sync2 & ~sync3;
   assign count_full = &count_o;

   // State, window counter and result registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state    <= IDLE;
         gate_rem <= '0;
         count_o  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_next;
         gate_rem <= gate_rem_next;
         count_o  <= count_next;
         overflow <= overflow_next;
      end
   end

   // Next-state and result update.
   // Results are cleared on the edge that enters ARM, so they already read
   // zero during the ARM cycle.
   // The window length is sampled only in ARM. Later changes to gate_cycles
   // therefore cannot disturb a running window.
   // In COUNT, gate_rem is never 0, because ARM sends a zero-length window
   // straight to DONE. The "<= 1" test is a defensive choice so that a
   // corrupted gate_rem still terminates the window.
   always_comb begin
      state_next    = state;
      gate_rem_next = gate_rem;
      count_next    = count_o;
      overflow_next = overflow;

      if (abort) begin
         state_next    = IDLE;
         gate_rem_next = '0;
         count_next    = '0;
         overflow_next = 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state_next    = ARM;
                  count_next    = '0;
                  overflow_next = 1'b0;
               end
            end

            ARM: begin
               gate_rem_next = gate_cycles;
               if (gate_cycles == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = COUNT;
               end
            end

            COUNT: begin
               gate_rem_next = gate_rem - GATE_W'(1);
               if (gate_rem <= GATE_W'(1)) begin
                  state_next = DONE;
               end
               if (ro_rise) begin
                  if (count_full) begin
                     overflow_next = 1'b1;
                  end else begin
                     count_next = count_o + CNT_W'(1);
                  end
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // busy and done are decoded from the next state and then registered.
   // They line up with the state register and never glitch.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == ARM) || (state_next == COUNT);
         done <= (state_next == DONE);
      end
   end

`ifdef RO_FREQ_IRQ_EN
   logic irq_q;

   // The pulse fires only on the edge that enters DONE. It covers entry
   // from COUNT and the zero-length path from ARM. A DONE that is simply
   // being held does not fire it again.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (state_next == DONE) && (state != DONE);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ro_freq_counter.sv
// ---------------------------------------------------------------------------
// tb_ro_freq_counter
//
// Purpose:
//   Self-checking bench for ro_freq_counter.
//   Two instances share all inputs:
//     - dut  uses the default parameters.
//     - dut4 uses CNT_W=4, so saturation and overflow can be observed.
//   Directed measurement vectors come from a table. Abort and reset behaviour
//   is exercised by hand-written sequences.
//
//   ro_in comes from a divider that toggles every ro_half clocks, so its
//   period is 2*ro_half clocks. ro_half == 0 holds ro_in low.
//   Every window length in the table is a whole number of ro_in periods, so
//   the expected count is exact whatever the phase.
//
// Build option:
//   RO_FREQ_IRQ_EN - selects whether irq pulses are expected.
// ---------------------------------------------------------------------------
module tb_ro_freq_counter;

`ifdef RO_FREQ_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        wb_clk_i;
   logic        wb_rst_ni;
   logic        ro_in;
   logic        start;
   logic        abort;
   logic [15:0] gate_cycles;

   logic [23:0] count_o;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        irq;

   logic [3:0]  count4;
   logic        busy4;
   logic        done4;
   logic        overflow4;
   logic        irq4;

   int          checks;
   int          failures;
   int          ro_half;
   int          ro_cnt;

   typedef struct {
      int gate;
      int gate_late;
      int half;
      int exp_count;
      int exp_latency;
      int exp_count4;
      int exp_ovf4;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   ro_freq_counter #(.CNT_W(24), .GATE_W(16)) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_ni   (wb_rst_ni),
      .ro_in       (ro_in),
      .start       (start),
      .abort       (abort),
      .gate_cycles (gate_cycles),
      .count_o     (count_o),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .irq         (irq)
   );

   ro_freq_counter #(.CNT_W(4), .GATE_W(16)) dut4 (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_ni   (wb_rst_ni),
      .ro_in       (ro_in),
      .start       (start),
      .abort       (abort),
      .gate_cycles (gate_cycles),
      .count_o     (count4),
      .busy        (busy4),
      .done        (done4),
      .overflow    (overflow4),
      .irq         (irq4)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // ro_in divider. It changes 2 time units after each rising clock edge,
   // well clear of the edge itself.
   initial begin
      ro_in  = 1'b0;
      ro_cnt = 0;
      forever begin
         @(posedge wb_clk_i);
         #2;
         if (ro_half == 0) begin
            ro_in  = 1'b0;
            ro_cnt = 0;
         end else begin
            ro_cnt = ro_cnt + 1;
            if (ro_cnt >= ro_half) begin
               ro_cnt = 0;
               ro_in  = ~ro_in;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One measurement: start, follow the window to DONE, then check the
   // latency, the results, the irq pulse and that DONE holds.
   task automatic applyStimulus(input int idx, input vec_t v);
      int k;
      int latency;
      int early_irq;
      bit seen;
      logic [23:0] held_count;
      ro_half     = v.half;
      gate_cycles = v.gate[15:0];
      repeat (20) @(posedge wb_clk_i);
      #1 start = 1'b1;
      @(posedge wb_clk_i);
      #1 start = 1'b0;
      seen      = 1'b0;
      early_irq = 0;
      for (k = 0; k <= v.exp_latency + 20; k++) begin
         @(negedge wb_clk_i);
         if (k == 0) begin
            checkOutput($sformatf("v%0d_arm_busy", idx), busy, 1);
            checkOutput($sformatf("v%0d_arm_count", idx), count_o, 0);
            checkOutput($sformatf("v%0d_arm_ovf4", idx), overflow4, 0);
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (irq) early_irq = early_irq + 1;
         @(posedge wb_clk_i);
         #1;
         if (k == 0) gate_cycles = v.gate_late[15:0];
      end
      latency = seen ? k + 1 : -1;
      checkOutput($sformatf("v%0d_latency", idx), latency, v.exp_latency);
      checkOutput($sformatf("v%0d_count", idx), count_o, v.exp_count);
      checkOutput($sformatf("v%0d_ovf", idx), overflow, 0);
      checkOutput($sformatf("v%0d_busy_done", idx), busy, 0);
      checkOutput($sformatf("v%0d_irq", idx), irq, IRQ_ON);
      checkOutput($sformatf("v%0d_early_irq", idx), early_irq, 0);
      checkOutput($sformatf("v%0d_count4", idx), count4, v.exp_count4);
      checkOutput($sformatf("v%0d_ovf4", idx), overflow4, v.exp_ovf4);
      held_count = count_o;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checkOutput($sformatf("v%0d_done_hold", idx), done, 1);
      checkOutput($sformatf("v%0d_irq_drop", idx), irq, 0);
      checkOutput($sformatf("v%0d_count_hold", idx), count_o, held_count);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      ro_half     = 0;
      wb_rst_ni   = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      gate_cycles = 16'd0;

      //           gate late half cnt  lat  c4  o4
      vecs[0]  = '{100, 100, 2, 25, 102, 15, 1};
      vecs[1]  = '{0,   0,   2, 0,  2,   0,  0};
      vecs[2]  = '{40,  40,  2, 10, 42,  10, 0};
      vecs[3]  = '{60,  60,  3, 10, 62,  10, 0};
      vecs[4]  = '{64,  64,  4, 8,  66,  8,  0};
      vecs[5]  = '{40,  5,   2, 10, 42,  10, 0};
      vecs[6]  = '{20,  20,  0, 0,  22,  0,  0};
      vecs[7]  = '{1,   1,   0, 0,  3,   0,  0};
      vecs[8]  = '{60,  60,  2, 15, 62,  15, 0};
      vecs[9]  = '{64,  64,  2, 16, 66,  15, 1};
      vecs[10] = '{200, 200, 2, 50, 202, 15, 1};
      vecs[11] = '{16,  16,  2, 4,  18,  4,  0};

      // Reset state.
      #2;
      checkOutput("rst_count", count_o, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_ovf", overflow, 0);
      checkOutput("rst_irq", irq, 0);
      #21 wb_rst_ni = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);

      for (int i = 0; i < NV; i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Abort while in DONE: back to IDLE with cleared results.
      @(posedge wb_clk_i);
      #1 abort = 1'b1;
      @(posedge wb_clk_i);
      #1 abort = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("abort_done_done", done, 0);
      checkOutput("abort_done_count", count_o, 0);

      // Abort in COUNT cycle 50 together with start: abort wins and the
      // start is ignored.
      ro_half     = 2;
      gate_cycles = 16'd100;
      repeat (20) @(posedge wb_clk_i);
      #1 start = 1'b1;
      @(posedge wb_clk_i);
      #1 start = 1'b0;
      repeat (50) @(posedge wb_clk_i);
      #1;
      checkOutput("pre_abort_busy", busy, 1);
      checkOutput("pre_abort_count_nz", (count_o != 0), 1);
      abort = 1'b1;
      start = 1'b1;
      @(posedge wb_clk_i);
      #1 abort = 1'b0;
      start = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_count", count_o, 0);
      checkOutput("abort_ovf4", overflow4, 0);
      repeat (5) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checkOutput("abort_start_ignored", busy, 0);

      // Reset pulse in the middle of COUNT: outputs clear at once, then a
      // fresh measurement gives the full count.
      #1 start = 1'b1;
      @(posedge wb_clk_i);
      #1 start = 1'b0;
      repeat (30) @(posedge wb_clk_i);
      #3 wb_rst_ni = 1'b0;
      #1;
      checkOutput("midrst_count", count_o, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_ovf", overflow, 0);
      checkOutput("midrst_irq", irq, 0);
      repeat (2) @(posedge wb_clk_i);
      #3 wb_rst_ni = 1'b1;
      repeat (4) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checkOutput("postrst_busy", busy, 0);
      checkOutput("postrst_count", count_o, 0);
      applyStimulus(100, vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
